// File: rtl/trace_dispatch.sv
// -----------------------------------------------------------------------------
// trace_dispatch
//
// Feeds decoded trace records into the L1 split-cache model. Records arrive on
// a valid/ready handshake, are buffered in a small FIFO, and are routed to the
// instruction cache (code 2), the data cache (codes 0/1/3/4), or both caches
// (codes 8 = clear, 9 = print). Records with any other code are dropped and
// counted.
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - record handshake from the trace reader
//   in_n, in_add         - operation code and address of the incoming record
//   out_n, out_add       - record presented to both caches (shared bus)
//   i_valid/i_ready      - request handshake to the instruction cache
//   d_valid/d_ready      - request handshake to the data cache
//   stats_clr            - one-cycle pulse after a code-8 broadcast completes
//   disp_count           - records fully dispatched (wraps)
//   bad_count            - records dropped for an illegal code (saturates)
//   idle                 - nothing buffered and the dispatcher is in IDLE
// -----------------------------------------------------------------------------
module trace_dispatch #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_n,
    input  logic [AW-1:0] in_add,
    output logic [3:0]    out_n,
    output logic [AW-1:0] out_add,
    output logic          i_valid,
    input  logic          i_ready,
    output logic          d_valid,
    input  logic          d_ready,
    output logic          stats_clr,
    output logic [31:0]   disp_count,
    output logic [15:0]   bad_count,
    output logic          idle
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, SEND, BCAST} state_t;

    // ------------------------------------------------------------------
    // FIFO: storage array plus a registered head stage. The head register
    // is the registered read port of the array, which gives the one-cycle
    // "pop" step between acceptance and dispatch. The head entry counts
    // toward the DEPTH capacity.
    // ------------------------------------------------------------------
    logic [3:0]    mem_n   [DEPTH];
    logic [AW-1:0] mem_add [DEPTH];

    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] mem_count_reg;
    logic          head_valid_reg;
    logic [3:0]    head_n_reg;
    logic [AW-1:0] head_add_reg;

    logic [CW-1:0] total_count;
    logic          full, empty, push, load, consume;

    assign total_count = mem_count_reg + CW'(head_valid_reg);
    assign full        = (total_count == CW'(DEPTH));
    assign empty       = (total_count == '0);
    assign in_ready    = !full;
    assign push        = in_valid && !full;
    // Refill the head whenever it is free or being consumed this cycle.
    assign load        = (mem_count_reg != '0) && (!head_valid_reg || consume);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_n[wr_ptr_reg]   <= in_n;
            mem_add[wr_ptr_reg] <= in_add;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            mem_count_reg  <= '0;
            head_valid_reg <= 1'b0;
            head_n_reg     <= '0;
            head_add_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (load) begin
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                head_n_reg   <= mem_n[rd_ptr_reg];
                head_add_reg <= mem_add[rd_ptr_reg];
            end
            head_valid_reg <= load || (head_valid_reg && !consume);
            mem_count_reg  <= mem_count_reg + CW'(push) - CW'(load);
        end
    end

    // ------------------------------------------------------------------
    // Dispatch FSM
    // ------------------------------------------------------------------
    state_t        state_reg, state_next;
    logic [3:0]    out_n_reg, out_n_next;
    logic [AW-1:0] out_add_reg, out_add_next;
    logic          i_valid_reg, i_valid_next;
    logic          d_valid_reg, d_valid_next;
    logic          stats_clr_reg, stats_clr_next;
    logic [31:0]   disp_count_reg, disp_count_next;
    logic [15:0]   bad_count_reg, bad_count_next;

    always_comb begin
        state_next      = state_reg;
        out_n_next      = out_n_reg;
        out_add_next    = out_add_reg;
        i_valid_next    = i_valid_reg;
        d_valid_next    = d_valid_reg;
        stats_clr_next  = 1'b0;
        disp_count_next = disp_count_reg;
        bad_count_next  = bad_count_reg;
        consume         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (head_valid_reg) begin
                    consume = 1'b1;
                    case (head_n_reg)
                        4'd2: begin
                            out_n_next   = head_n_reg;
                            out_add_next = head_add_reg;
                            i_valid_next = 1'b1;
                            state_next   = SEND;
                        end
                        4'd0, 4'd1, 4'd3, 4'd4: begin
                            out_n_next   = head_n_reg;
                            out_add_next = head_add_reg;
                            d_valid_next = 1'b1;
                            state_next   = SEND;
                        end
                        4'd8, 4'd9: begin
                            out_n_next   = head_n_reg;
                            out_add_next = head_add_reg;
                            i_valid_next = 1'b1;
                            d_valid_next = 1'b1;
                            state_next   = BCAST;
                        end
                        default: begin
                            // Illegal code: dropped without touching the bus.
                            if (bad_count_reg != 16'hFFFF) begin
                                bad_count_next = bad_count_reg + 16'd1;
                            end
                        end
                    endcase
                end
            end
            SEND: begin
                // Exactly one valid is high here, so either handshake ends it.
                if ((i_valid_reg && i_ready) || (d_valid_reg && d_ready)) begin
                    i_valid_next    = 1'b0;
                    d_valid_next    = 1'b0;
                    disp_count_next = disp_count_reg + 32'd1;
                    state_next      = IDLE;
                end
            end
            BCAST: begin
                if (i_valid_reg && i_ready) begin
                    i_valid_next = 1'b0;
                end
                if (d_valid_reg && d_ready) begin
                    d_valid_next = 1'b0;
                end
                if (!i_valid_next && !d_valid_next) begin
                    disp_count_next = disp_count_reg + 32'd1;
                    stats_clr_next  = (out_n_reg == 4'd8);
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            out_n_reg      <= '0;
            out_add_reg    <= '0;
            i_valid_reg    <= 1'b0;
            d_valid_reg    <= 1'b0;
            stats_clr_reg  <= 1'b0;
            disp_count_reg <= '0;
            bad_count_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            out_n_reg      <= out_n_next;
            out_add_reg    <= out_add_next;
            i_valid_reg    <= i_valid_next;
            d_valid_reg    <= d_valid_next;
            stats_clr_reg  <= stats_clr_next;
            disp_count_reg <= disp_count_next;
            bad_count_reg  <= bad_count_next;
        end
    end

    assign out_n      = out_n_reg;
    assign out_add    = out_add_reg;
    assign i_valid    = i_valid_reg;
    assign d_valid    = d_valid_reg;
    assign stats_clr  = stats_clr_reg;
    assign disp_count = disp_count_reg;
    assign bad_count  = bad_count_reg;
    assign idle       = empty && (state_reg == IDLE);

endmodule

// File: doc/trace_dispatch.md
# trace_dispatch

Upstream feeder for the L1 split-cache model. It accepts decoded trace records (operation code `n`, 32-bit address) from the trace-file reader through a valid/ready handshake and buffers them in a small FIFO. It routes each record to the instruction cache, the data cache, or both, and counts dispatched and rejected records. It sits between the file-input process and the INS_CACHE/DATA_CACHE pair, replacing the direct `n`/`i_add`/`d_add` streaming.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `AW`, 32: address width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: a trace record is present.
- `in_ready` out 1: FIFO can accept; equals `!full`, combinational.
- `in_n` in 4: trace operation code.
- `in_add` in AW: trace address.
- `out_n` out 4: operation code presented to the caches (shared by both).
- `out_add` out AW: address presented to the caches (shared by both).
- `i_valid` out 1: request to the instruction cache.
- `i_ready` in 1: instruction cache accepts.
- `d_valid` out 1: request to the data cache.
- `d_ready` in 1: data cache accepts.
- `stats_clr` out 1: one-cycle pulse when a code-8 broadcast completes.
- `disp_count` out 32: records fully dispatched; wraps at 2^32.
- `bad_count` out 16: records dropped for an illegal code; saturates at 16'hFFFF.
- `idle` out 1: FIFO empty and FSM in IDLE.

## Operation
- Codes:
  - 2 → instruction cache.
  - 0, 1, 3, 4 → data cache.
  - 8 (clear) and 9 (print) → both caches.
  - Any other code is illegal.
- FIFO:
  - Push when `in_valid && in_ready`.
  - No write-through bypass: a record pushed into a full-minus-one FIFO makes `in_ready` low on the next cycle.
  - Pop and push may occur in the same cycle when not full.
- FSM states: IDLE, SEND, BCAST.
  - **IDLE:** if the FIFO is non-empty, pop the head and register it into `out_n`/`out_add`.
    - Code 2: set `i_valid` and go to SEND.
    - Codes 0/1/3/4: set `d_valid` and go to SEND.
    - Codes 8/9: set both valids and go to BCAST.
    - Illegal code: pop, do not present, `bad_count`+1 (saturating), stay in IDLE.
  - **SEND:** hold `out_n`, `out_add` and the asserted valid stable until the matching ready is sampled high at a rising edge. On that edge, clear the valid, increment `disp_count`, and return to IDLE.
  - **BCAST:** `i_valid` and `d_valid` each clear independently on the edge where their own ready is high. On the edge where the last one clears (both may clear on the same edge):
    - `disp_count`+1 (a broadcast counts once);
    - if code 8, pulse `stats_clr` high the following cycle;
    - return to IDLE.
- A ready that is high while its valid is low is ignored.
- `idle` is combinational: `empty && state==IDLE`.

## Timing
- Reset values: FIFO empty (`in_ready`=1), state IDLE, `i_valid`=`d_valid`=0, `out_n`=0, `out_add`=0, `stats_clr`=0, `disp_count`=0, `bad_count`=0, `idle`=1.
- Latency:
  - Record accepted at edge T → popped at edge T+1 → valid high after edge T+2.
  - With the target ready held high, the valid is high for exactly one cycle.
  - Throughput: one record per 2 cycles (one bubble in IDLE between requests).
- Full FIFO: `in_ready` low; `in_valid` is ignored and no record is lost or overwritten.
- Back-pressure: `out_*` must not change while any valid is high.
- Reset asserted mid-operation: on the reset edge the FIFO is flushed, valids drop, and counters clear. Outstanding requests are abandoned with no count.
- Reset has priority over push, pop and count updates on the same edge.
- `disp_count` wraps from 32'hFFFFFFFF to 0. `bad_count` holds at 16'hFFFF.

## Test plan
- **Single records:** push code 2, addr 0x0000_1000 with `i_ready`=1 → `i_valid` for one cycle at T+2 with `out_add`=0x1000, `d_valid` stays 0, `disp_count`=1. Repeat with code 1, addr 0xDEAD_BEEF → `d_valid` path only.
- **Back-pressure:** hold `d_ready`=0 for 10 cycles and push 6 code-0 records → `in_ready` low after 4 are buffered plus 1 in flight. Release `d_ready` → all 6 delivered in push order with `out_add` stable while stalled, and `disp_count`=6.
- **Broadcast:** push code 8 with `i_ready`=1 and `d_ready` going high 3 cycles later → `i_valid` clears first, `d_valid` clears later, `stats_clr` pulses exactly once after `d_valid` clears, `disp_count`+1. Push code 9 → no `stats_clr`.
- **Illegal codes:** push codes 5, 7, 15 interleaved with a code-2 record → only the code-2 record is dispatched, `bad_count`=3, `idle`=1 afterwards.
- **Reset mid-stall:** 3 records queued, `i_valid` stalled, assert `rst` for one edge → next cycle all outputs at reset values, `in_ready`=1, no further requests.
- **Saturation and wrap:** force `bad_count` to 16'hFFFE and drop 3 illegal records → value 16'hFFFF. Preload `disp_count` to all-ones and dispatch one record → 0.
